// File: rtl/arm_operand2_shifter.sv
// Two-stage operand-2 generator: decode to (type, amount), then shift/rotate with carry-out.
// Optional RRX for shift-by-immediate ROR #0 is built only when ARM_SHIFTER_RRX_EN is defined.
module arm_operand2_shifter #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [1:0]       shift_type,
    input  logic [WIDTH-1:0] operand,
    input  logic [11:0]      imm12,
    input  logic [SW-1:0]    shamt_imm,
    input  logic [7:0]       shamt_reg,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    typedef enum logic [2:0] {
        T_LSL  = 3'd0,
        T_LSR  = 3'd1,
        T_ASR  = 3'd2,
        T_ROR  = 3'd3,
        T_RRX  = 3'd4,
        T_PASS = 3'd5,
        T_ZERO = 3'd6
    } shift_t;

    localparam logic [SW:0] AMT_FULL = (SW+1)'(WIDTH);

    logic             s1_valid_reg;
    shift_t           s1_type_reg;
    logic [SW:0]      s1_amt_reg;
    logic [WIDTH-1:0] s1_operand_reg;
    logic             s1_carry_reg;
    logic             s2_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;

    logic             s2_advance;
    shift_t           type_next;
    logic [SW:0]      amt_next;
    logic [WIDTH-1:0] operand_next;
    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic [31:0]      n_reg_full;
    logic [31:0]      rot_full;
    logic [WIDTH:0]   ext_l;
    logic [WIDTH:0]   ext_r;
    logic [WIDTH:0]   ext_a;
    logic [SW:0]      rot_back;

    assign s2_advance = !s2_valid_reg || out_ready;
    assign in_ready   = !s1_valid_reg || s2_advance;
    assign out_valid  = s2_valid_reg;
    assign result     = result_reg;
    assign carry_out  = carry_reg;

    // Decode: every special case collapses to a type plus an amount in 0..WIDTH.
    always_comb begin
        type_next    = T_PASS;
        amt_next     = '0;
        operand_next = operand;
        n_reg_full   = 32'(shamt_reg);
        rot_full     = (32'(imm12[11:8]) << 1) % WIDTH;
        case (mode)
            2'd0: begin
                operand_next = WIDTH'(imm12[7:0]);
                if (rot_full != 0) begin
                    type_next = T_ROR;
                    amt_next  = (SW+1)'(rot_full);
                end
            end
            2'd1: begin
                type_next = shift_t'({1'b0, shift_type});
                amt_next  = {1'b0, shamt_imm};
                if (shamt_imm == '0) begin
                    case (shift_type)
                        2'd0: type_next = T_PASS;
`ifdef ARM_SHIFTER_RRX_EN
                        2'd3: type_next = T_RRX;
`else
                        2'd3: type_next = T_PASS;
`endif
                        default: amt_next = AMT_FULL;
                    endcase
                end
            end
            2'd2: begin
                type_next = shift_t'({1'b0, shift_type});
                if (n_reg_full == 0) begin
                    type_next = T_PASS;
                end else if (shift_type == 2'd3) begin
                    amt_next = (n_reg_full % WIDTH == 0) ? AMT_FULL : (SW+1)'(n_reg_full % WIDTH);
                end else if (n_reg_full > WIDTH) begin
                    type_next = (shift_type == 2'd2) ? T_ASR : T_ZERO;
                    amt_next  = AMT_FULL;
                end else begin
                    amt_next = (SW+1)'(n_reg_full);
                end
            end
            default: type_next = T_PASS;
        endcase
    end

    // One guard bit on the widened operand catches the last bit shifted out.
    always_comb begin
        result_next = s1_operand_reg;
        carry_next  = s1_carry_reg;
        ext_l       = {1'b0, s1_operand_reg} << s1_amt_reg;
        ext_r       = {s1_operand_reg, 1'b0} >> s1_amt_reg;
        ext_a       = $signed({s1_operand_reg, 1'b0}) >>> s1_amt_reg;
        rot_back    = AMT_FULL - s1_amt_reg;
        case (s1_type_reg)
            T_LSL: {carry_next, result_next} = ext_l;
            T_LSR: {result_next, carry_next} = ext_r;
            T_ASR: {result_next, carry_next} = ext_a;
            T_ROR: begin
                result_next = (s1_operand_reg >> s1_amt_reg) | (s1_operand_reg << rot_back);
                carry_next  = result_next[WIDTH-1];
            end
`ifdef ARM_SHIFTER_RRX_EN
            T_RRX: begin
                result_next = {s1_carry_reg, s1_operand_reg[WIDTH-1:1]};
                carry_next  = s1_operand_reg[0];
            end
`endif
            T_ZERO: begin
                result_next = '0;
                carry_next  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_type_reg    <= T_PASS;
            s1_amt_reg     <= '0;
            s1_operand_reg <= '0;
            s1_carry_reg   <= 1'b0;
            s2_valid_reg   <= 1'b0;
            result_reg     <= '0;
            carry_reg      <= 1'b0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_type_reg    <= type_next;
                    s1_amt_reg     <= amt_next;
                    s1_operand_reg <= operand_next;
                    s1_carry_reg   <= carry_in;
                end
            end
            if (s2_advance) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    result_reg <= result_next;
                    carry_reg  <= carry_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_arm_operand2_shifter.sv
// Self-checking bench for arm_operand2_shifter: directed plan vectors, stall/flush/reset
// scenarios and a randomized stream checked against a bit-serial reference model.
module tb_arm_operand2_shifter;
    localparam int WIDTH = 32;
    localparam int SW    = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        mode = '0;
    logic [1:0]        shift_type = '0;
    logic [WIDTH-1:0]  operand = '0;
    logic [11:0]       imm12 = '0;
    logic [SW-1:0]     shamt_imm = '0;
    logic [7:0]        shamt_reg = '0;
    logic              carry_in = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  result;
    logic              carry_out;

    arm_operand2_shifter #(.WIDTH(WIDTH), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .shift_type(shift_type), .operand(operand), .imm12(imm12),
        .shamt_imm(shamt_imm), .shamt_reg(shamt_reg), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        c;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_acc = 0;
    logic        chk_lat = 1'b0;
    logic [31:0] exp_r = '0;
    logic        exp_c = 1'b0;

    // Architectural definition: shift one bit at a time, carry is the last bit moved out.
    function automatic logic [32:0] model(input logic [1:0] m, input logic [1:0] st,
                                          input logic [31:0] op, input logic [11:0] imm,
                                          input logic [4:0] shi, input logic [7:0] shr,
                                          input logic ci);
        logic [31:0] r;
        logic        c;
        int          n;
        r = op;
        c = ci;
        case (m)
            2'd0: begin
                r = {24'b0, imm[7:0]};
                n = 2 * int'(imm[11:8]);
                for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
                if (n % 32 != 0) c = r[31];
                return {c, r};
            end
            2'd3: return {ci, op};
            2'd1: begin
                n = int'(shi);
                if (n == 0) begin
                    if (st == 2'd0) return {ci, op};
`ifdef ARM_SHIFTER_RRX_EN
                    if (st == 2'd3) return {op[0], ci, op[31:1]};
`else
                    if (st == 2'd3) return {ci, op};
`endif
                    n = 32;
                end
            end
            default: begin
                n = int'(shr);
                if (n == 0) return {ci, op};
                if (st == 2'd3 && n % 32 == 0) return {op[31], op};
            end
        endcase
        for (int i = 0; i < n; i++) begin
            case (st)
                2'd0: begin c = r[31]; r = r << 1; end
                2'd1: begin c = r[0];  r = r >> 1; end
                2'd2: begin c = r[0];  r = {r[31], r[31:1]}; end
                default: begin c = r[0]; r = {r[0], r[31:1]}; end
            endcase
        end
        return {c, r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called once per cycle, mid-cycle: checks outputs and handshakes, updates the scoreboard.
    task automatic eval();
        check("in_ready", {63'b0, in_ready}, {63'b0, (q.size() < 2) || out_ready});
        if (out_valid) begin
            n_cmp++;
            assert (q.size() != 0) else begin
                n_bad++;
                $error("FAIL spurious_out: out_valid=1 expected no pending op");
            end
            if (q.size() != 0) begin
                check("result", {32'b0, result}, {32'b0, q[0].r});
                check("carry", {63'b0, carry_out}, {63'b0, q[0].c});
                if (out_ready) begin
                    if (chk_lat) check("latency", 64'(cyc - q[0].acc), 64'd2);
                    $display("xfer cyc=%0d result=0x%08h carry=%b", cyc, result, carry_out);
                    void'(q.pop_front());
                end
            end
        end
        if (flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            q.push_back('{r: exp_r, c: exp_c, acc: cyc});
            n_acc++;
        end
    endtask

    task automatic tick();
        #1;
        eval();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic set_op(input logic [1:0] m, input logic [1:0] st, input logic [31:0] op,
                          input logic [11:0] imm, input logic [4:0] shi, input logic [7:0] shr,
                          input logic ci);
        mode = m; shift_type = st; operand = op; imm12 = imm;
        shamt_imm = shi; shamt_reg = shr; carry_in = ci;
    endtask

    task automatic run_one(input logic [1:0] m, input logic [1:0] st, input logic [31:0] op,
                           input logic [11:0] imm, input logic [4:0] shi, input logic [7:0] shr,
                           input logic ci, input logic [31:0] er, input logic ec);
        set_op(m, st, op, imm, shi, shr, ci);
        exp_r = er;
        exp_c = ec;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("accept_ready", {63'b0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        drain();
    endtask

    task automatic rand_inputs();
        logic [7:0] picks[6];
        picks = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'($urandom)};
        mode       = 2'($urandom_range(0, 3));
        shift_type = 2'($urandom_range(0, 3));
        operand    = $urandom;
        imm12      = 12'($urandom);
        shamt_imm  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        shamt_reg  = picks[$urandom_range(0, 5)];
        carry_in   = 1'($urandom);
        {exp_c, exp_r} = model(mode, shift_type, operand, imm12, shamt_imm, shamt_reg, carry_in);
    endtask

    initial begin
        logic [31:0] rrx_r;
        int          start;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_result", {32'b0, result}, 64'd0);
        check("rst_carry", {63'b0, carry_out}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);

        // Plan vectors
        chk_lat = 1'b1;
        run_one(2'd0, 2'd0, 32'h1234_5678, 12'h4FF, 5'd0, 8'd0, 1'b0, 32'hFF00_0000, 1'b1);
        chk_lat = 1'b0;
        run_one(2'd2, 2'd0, 32'h8000_0001, 12'h0, 5'd0, 8'd32, 1'b0, 32'h0, 1'b1);
        run_one(2'd2, 2'd0, 32'h8000_0001, 12'h0, 5'd0, 8'd33, 1'b1, 32'h0, 1'b0);
        run_one(2'd2, 2'd0, 32'h8000_0001, 12'h0, 5'd0, 8'd0, 1'b1, 32'h8000_0001, 1'b1);
        run_one(2'd1, 2'd2, 32'h8000_0000, 12'h0, 5'd0, 8'd0, 1'b0, 32'hFFFF_FFFF, 1'b1);
`ifdef ARM_SHIFTER_RRX_EN
        rrx_r = 32'h8000_0001;
`else
        rrx_r = 32'h0000_0003;
`endif
        run_one(2'd1, 2'd3, 32'h0000_0003, 12'h0, 5'd0, 8'd0, 1'b1, rrx_r, 1'b1);
        run_one(2'd2, 2'd1, 32'h8000_0001, 12'h0, 5'd0, 8'd32, 1'b0, 32'h0, 1'b1);
        run_one(2'd2, 2'd3, 32'h8000_0001, 12'h0, 5'd0, 8'd64, 1'b0, 32'h8000_0001, 1'b1);
        run_one(2'd3, 2'd0, 32'hCAFE_F00D, 12'h0, 5'd0, 8'd7, 1'b0, 32'hCAFE_F00D, 1'b0);

        // Stream of 8 ops with a 3-cycle output stall once the pipe is full
        start = n_acc;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && (n_acc - start) < 8; i++) begin
            rand_inputs();
            out_ready = !(i >= 3 && i < 6);
            #1;
            if (i >= 3 && i < 6) check("full_in_ready", {63'b0, in_ready}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(n_acc - start), 64'd8);
        drain();

        // Flush with both stages valid and a new input offered
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_inputs(); tick();
        rand_inputs(); tick();
        out_ready = 1'b1;
        flush = 1'b1;
        rand_inputs(); tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_out_valid", {63'b0, out_valid}, 64'd0);
        check("flush_in_ready", {63'b0, in_ready}, 64'd1);
        tick();
        repeat (2) tick();
        run_one(2'd1, 2'd1, 32'hF000_0000, 12'h0, 5'd4, 8'd0, 1'b0, 32'h0F00_0000, 1'b0);

        // Randomized traffic with back-pressure and occasional flush
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset while a result is being held
        set_op(2'd3, 2'd0, 32'hDEAD_BEEF, 12'h0, 5'd0, 8'd0, 1'b1);
        exp_r = 32'hDEAD_BEEF;
        exp_c = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        check("pre_rst_out_valid", {63'b0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'b0, out_valid}, 64'd0);
        check("arst_result", {32'b0, result}, 64'd0);
        check("arst_carry", {63'b0, carry_out}, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/arm_operand2_shifter.md
# arm_operand2_shifter

Parametrised, pipelined operand-2 generator for the ARM data-processing datapath. It produces the shifted or rotated second operand and the shifter carry-out for all three operand-2 forms: 8-bit immediate with even rotate, register shifted by an immediate, and register shifted by a register. It sits between register read and the ALU. It has a two-stage valid/ready pipeline so that ALU back-pressure and pipeline flushes are absorbed locally.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8.
- SW, $clog2(WIDTH), width of the immediate shift amount.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- flush  in  1  synchronous kill of every in-flight operation.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept the input this cycle.
- mode  in  2  0 = immediate rotate, 1 = shift by immediate, 2 = shift by register, 3 = pass-through.
- shift_type  in  2  0 = LSL, 1 = LSR, 2 = ASR, 3 = ROR.
- operand  in  WIDTH  Rm value.
- imm12  in  12  rotate field [11:8] plus 8-bit constant [7:0].
- shamt_imm  in  SW  immediate shift amount.
- shamt_reg  in  8  Rs[7:0].
- carry_in  in  1  current CPSR C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  shifted operand.
- carry_out  out  1  shifter carry.

## Operation
- Stage 1 (decode) registers an effective type (LSL/LSR/ASR/ROR/RRX/PASS), an effective amount (0..WIDTH), the operand and carry_in.
- Stage 2 computes result and carry_out and holds them until they are accepted.
- Immediate rotate: result = ROR(zero-extend(imm12[7:0]), (2·imm12[11:8]) mod WIDTH). carry_out = carry_in if the rotate amount is 0, otherwise result[WIDTH-1]. mode 0 ignores operand.
- Shift by immediate:
  - LSL #0 is pass-through with C = carry_in.
  - LSR #0 and ASR #0 mean an amount of WIDTH.
  - ROR #0 means RRX (see Configuration).
- Shift by register, with n = shamt_reg:
  - n = 0: pass-through, C = carry_in.
  - LSL n = WIDTH: result 0, C = operand[0]. LSL n > WIDTH: result 0, C = 0.
  - LSR n = WIDTH: result 0, C = operand[WIDTH-1]. LSR n > WIDTH: result 0, C = 0.
  - ASR n ≥ WIDTH: every bit = operand[WIDTH-1], C = operand[WIDTH-1].
  - ROR with n mod WIDTH = 0 (n ≠ 0): result = operand, C = operand[WIDTH-1]. Otherwise rotate by n mod WIDTH.
- General carry for 0 < n < WIDTH:
  - LSL: C = operand[WIDTH-n].
  - LSR/ASR/ROR: C = operand[n-1].
- mode 3: result = operand, C = carry_in.

## Timing
- Reset values: out_valid 0, result 0, carry_out 0, and both internal valid bits 0. in_ready is 1 once reset is released.
- Latency: 2 cycles from input acceptance (in_valid & in_ready) to out_valid.
- Throughput: 1 operation per cycle while out_ready stays high.
- Handshake:
  - A stage advances when it is empty or when its downstream accepts in the same cycle.
  - in_ready = !s1_valid | s2 advancing. in_ready is combinational on out_ready; there is no other combinational input-to-output path.
  - While out_valid = 1 and out_ready = 0, result and carry_out are held stable.
- Full: both stages valid and out_ready = 0 → in_ready = 0. Input is not consumed.
- Simultaneous accept and issue at full occupancy with out_ready = 1: all stages shift and the new input is accepted in the same cycle.
- Flush clears both valid bits on the next edge and overrides any acceptance that cycle. in_ready is 1 in the cycle after a flush.
- Asynchronous reset asserted mid-operation clears all valids immediately. No partial result is ever presented.

## Configuration
- ARM_SHIFTER_RRX_EN defined: shift-by-immediate ROR #0 performs RRX: result = {carry_in, operand[WIDTH-1:1]}, C = operand[0].
- ARM_SHIFTER_RRX_EN undefined: ROR #0 is pass-through with C = carry_in. The RRX logic is not built.

## Test plan
- WIDTH=32, mode 0, imm12=0x4FF, carry_in=0 → result 0xFF000000, carry_out 1, out_valid exactly 2 cycles after acceptance.
- mode 2, LSL, operand 0x80000001, shamt_reg 32 → result 0, C=1. shamt_reg 33 → result 0, C=0. shamt_reg 0 with carry_in=1 → result 0x80000001, C=1.
- mode 1, ASR, shamt_imm 0, operand 0x80000000 → result 0xFFFFFFFF, C=1. ROR #0 with carry_in 1 and operand 0x00000003 → 0x80000001, C=1 when the macro is defined; 0x00000003, C=1 when it is undefined.
- Back-to-back stream of 8 ops with out_ready held low for 3 cycles mid-stream → in_ready drops after 2 held ops, no loss or duplication, results in order, held outputs stable.
- flush asserted with both stages valid and in_valid=1 → out_valid 0 next cycle, the flush-cycle input is dropped, and the next op is accepted normally.
- rst_n pulsed low asynchronously while out_valid=1 → out_valid, result, carry_out go to 0 without waiting for a clock edge.
